polirv_stim_driver: RTL and testbench
=====================================

# polirv_stim_driver

Synthesisable, parametrised stimulus driver for the polirv core: replaces hand-toggled reset and instruction sequences with a loadable instruction table, a reset-sequencing FSM, and run/halt/store monitoring. It sits beside the core in simulation and FPGA bring-up. It drives the core's active-low reset and `i_mem_data`, and observes `i_mem_addr` and `d_mem_we`.

## Interface
- `I_ADDR_BITS`, 6: width of the core instruction address and of the table index.
- `DEPTH`, 64: number of table entries; must satisfy 1 ≤ DEPTH ≤ 2**I_ADDR_BITS.
- `INSTRUCTION_SIZE`, 32: instruction width.
- `RESET_CYCLES`, 2: number of cycles `core_rst_n` is held low after `start`; must be ≥ 1.
- `CNT_BITS`, 16: width of the cycle and store counters and of `run_limit`.
- `HALT_REPEAT`, 4: number of consecutive identical `i_mem_addr` samples in RUN that declare a halt; must be ≥ 2.
- `NOP`, 32'h00000013: word driven when no table word applies.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `load_we` in 1: table write strobe.
- `load_addr` in I_ADDR_BITS: table write index.
- `load_data` in INSTRUCTION_SIZE: table write word.
- `start` in 1: single-cycle run request.
- `abort` in 1: cancels a run in progress.
- `run_limit` in CNT_BITS: maximum number of RUN cycles; sampled when `start` is accepted.
- `core_rst_n` out 1: active-low reset to the core.
- `i_mem_addr` in I_ADDR_BITS: instruction address from the core.
- `i_mem_data` out INSTRUCTION_SIZE: instruction to the core.
- `d_mem_we` in 1: data-store strobe from the core.
- `busy` out 1: high in RESET and RUN.
- `done` out 1: high in DONE.
- `halted` out 1: the last run ended on halt detection.
- `timeout` out 1: the last run ended on `run_limit`.
- `cycle_count` out CNT_BITS: number of RUN cycles elapsed.
- `store_count` out CNT_BITS: number of RUN cycles with `d_mem_we` high.

## Operation
- FSM states: IDLE, RESET, RUN, DONE. Reset puts the FSM in IDLE.
- IDLE and DONE:
  - `core_rst_n`=0 and `i_mem_data`=NOP.
  - A `load_we` with `load_addr` < DEPTH writes the table; a write with `load_addr` ≥ DEPTH is dropped.
  - `start`=1 moves to RESET. It also clears `cycle_count`, `store_count`, `halted` and `timeout`, and latches `run_limit`.
- RESET:
  - `core_rst_n`=0 for exactly RESET_CYCLES cycles, then the FSM enters RUN.
  - `load_we` is ignored.
- RUN:
  - `core_rst_n`=1.
  - `i_mem_data` = table[`i_mem_addr`] through a combinational read in the same cycle. If `i_mem_addr` ≥ DEPTH, `i_mem_data`=NOP.
  - `cycle_count` increments every cycle.
  - `store_count` increments on each cycle with `d_mem_we`=1.
  - `load_we` is ignored.
- Halt detection:
  - A repeat counter compares `i_mem_addr` with the previous RUN-cycle sample.
  - The first RUN cycle always loads the counter with 1.
  - Each equal sample increments the counter; an unequal sample resets it to 1.
  - The counter reaching HALT_REPEAT sets `halted` and moves the FSM to DONE.
- Limit: `cycle_count` reaching the latched limit sets `timeout` and moves the FSM to DONE.
  - A latched limit of 0 moves RESET directly to DONE with `timeout`=1 and `cycle_count`=0.
- Halt and limit in the same cycle: both `halted` and `timeout` are set.
- `abort` in RESET or RUN returns the FSM to IDLE next cycle.
  - Counters hold their values.
  - Both flags stay 0.
- `abort` in IDLE or DONE has no effect. `start` in RESET or RUN is ignored.
- Arithmetic: all counters are unsigned and saturate at 2**CNT_BITS−1; they do not wrap.
- Table contents are not affected by `rst`. Reading an unwritten entry returns an undefined value, and the bench must load every address it executes.
- `busy` = RESET|RUN, and `done` = DONE, both decoded from registered state.

## Timing
- Reset values:
  - `core_rst_n`=0, `busy`=0, `done`=0, `halted`=0, `timeout`=0.
  - `cycle_count`=0, `store_count`=0.
  - `i_mem_data`=NOP.
- `start` sampled high at edge t:
  - `busy`=1 from t+1.
  - `core_rst_n` rises at t+1+RESET_CYCLES; the first RUN cycle is that cycle.
- The counters and the halt detector sample inputs at the end of each RUN cycle. The values are visible the following cycle.
- With limit L and no halt, `done`=1 exactly L cycles after the first RUN cycle, with `cycle_count`=L.
- Entering DONE from RUN drops `core_rst_n` in the same edge that sets `done`.
- A table write at edge t is visible to a combinational read from t+1.
- `rst` overrides `start`, `abort` and `load_we` in the same cycle.
- `rst` asserted mid-run returns all outputs to their reset values on the next edge.

## Test plan
- Load 0x00500093 at address 0 and 0x0000006F at address 1, with run_limit=100, RESET_CYCLES=2, then start → `core_rst_n` low for 2 cycles. The model core loops at address 1, so halt fires with `halted`=1, `timeout`=0 and `cycle_count` equal to the first-address-1 cycle plus 3.
- Table filled with NOP and a PC-incrementing core model, run_limit=10 → `done` 10 cycles after `core_rst_n` rises, with `timeout`=1, `halted`=0 and `cycle_count`=10.
- run_limit=0 → DONE directly after RESET, with `timeout`=1, `cycle_count`=0, and `core_rst_n` never going high.
- Core address 40 while DEPTH=32 → `i_mem_data`=0x00000013. Also `load_we` to address 40, and `load_we` during RUN → the table is unchanged.
- `d_mem_we` high on 3 RUN cycles, then `abort` → FSM in IDLE next cycle with `store_count`=3, both flags 0 and `core_rst_n`=0.
- `rst` asserted in RUN together with `start` → all outputs return to their reset values. A previously loaded table word is still returned in the next run.

Source files
------------

// File: rtl/polirv_stim_driver.sv
// Stimulus driver for the polirv core: instruction table, reset sequencing,
// and run/halt/store monitoring for simulation and FPGA bring-up.
module polirv_stim_driver #(
    parameter int unsigned I_ADDR_BITS = 6,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned INSTRUCTION_SIZE = 32,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned CNT_BITS = 16,
    parameter int unsigned HALT_REPEAT = 4,
    parameter logic [INSTRUCTION_SIZE-1:0] NOP = 32'h00000013
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_we,
    input  logic [I_ADDR_BITS-1:0]      load_addr,
    input  logic [INSTRUCTION_SIZE-1:0] load_data,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CNT_BITS-1:0]         run_limit,
    output logic                        core_rst_n,
    input  logic [I_ADDR_BITS-1:0]      i_mem_addr,
    output logic [INSTRUCTION_SIZE-1:0] i_mem_data,
    input  logic                        d_mem_we,
    output logic                        busy,
    output logic                        done,
    output logic                        halted,
    output logic                        timeout,
    output logic [CNT_BITS-1:0]         cycle_count,
    output logic [CNT_BITS-1:0]         store_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(HALT_REPEAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t                      r_state;
    logic [RC_W-1:0]             r_rc;
    logic [REP_W-1:0]            r_rep;
    logic [I_ADDR_BITS-1:0]      r_prev;
    logic                        r_first;
    logic [CNT_BITS-1:0]         r_limit;
    logic [CNT_BITS-1:0]         r_cycle;
    logic [CNT_BITS-1:0]         r_store;
    logic                        r_halted;
    logic                        r_timeout;
    logic [INSTRUCTION_SIZE-1:0] r_mem [DEPTH];

    logic                        w_quiet;
    logic                        w_load_ok;
    logic                        w_rd_in;
    logic [IDX_W-1:0]            w_ld_idx;
    logic [IDX_W-1:0]            w_rd_idx;
    logic [INSTRUCTION_SIZE-1:0] w_rd_data;
    logic [CNT_BITS-1:0]         w_cyc_nxt;
    logic [CNT_BITS-1:0]         w_st_nxt;
    logic [REP_W-1:0]            w_rep_nxt;
    logic                        w_halt;
    logic                        w_lim;

    assign w_quiet   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_ld_idx  = load_addr[IDX_W-1:0];
    assign w_rd_idx  = i_mem_addr[IDX_W-1:0];
    assign w_load_ok = load_we && w_quiet && (32'(load_addr) < DEPTH);
    assign w_rd_in   = 32'(i_mem_addr) < DEPTH;
    assign w_rd_data = w_rd_in ? r_mem[w_rd_idx] : NOP;

    assign w_cyc_nxt = (&r_cycle) ? r_cycle : r_cycle + CNT_BITS'(1);
    assign w_st_nxt  = (d_mem_we && !(&r_store)) ? r_store + CNT_BITS'(1)
                                                 : r_store;

    // First RUN cycle has no previous sample, so it always restarts at 1.
    assign w_rep_nxt = (!r_first && (i_mem_addr == r_prev))
                     ? r_rep + REP_W'(1) : REP_W'(1);
    assign w_halt    = (w_rep_nxt == REP_MAX);
    assign w_lim     = (w_cyc_nxt == r_limit);

    assign core_rst_n  = (r_state == S_RUN);
    assign i_mem_data  = (r_state == S_RUN) ? w_rd_data : NOP;
    assign busy        = (r_state == S_RESET) || (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle;
    assign store_count = r_store;

    // Table storage deliberately survives rst.
    always_ff @(posedge clk) begin
        if (!rst && w_load_ok) begin
            r_mem[w_ld_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rc      <= '0;
            r_rep     <= '0;
            r_prev    <= '0;
            r_first   <= 1'b0;
            r_limit   <= '0;
            r_cycle   <= '0;
            r_store   <= '0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_RESET;
                        r_rc      <= '0;
                        r_limit   <= run_limit;
                        r_cycle   <= '0;
                        r_store   <= '0;
                        r_halted  <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_rc == RC_LAST) begin
                        if (r_limit == '0) begin
                            r_state   <= S_DONE;
                            r_timeout <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_first <= 1'b1;
                        end
                    end else begin
                        r_rc <= r_rc + RC_W'(1);
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cycle <= w_cyc_nxt;
                        r_store <= w_st_nxt;
                        r_prev  <= i_mem_addr;
                        r_rep   <= w_rep_nxt;
                        r_first <= 1'b0;
                        if (w_halt || w_lim) begin
                            r_state   <= S_DONE;
                            r_halted  <= w_halt;
                            r_timeout <= w_lim;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polirv_stim_driver.sv
// Directed bench for polirv_stim_driver with a tiny PC-stepping core model.
module tb_polirv_stim_driver;

    localparam int AW = 6;
    localparam int IW = 32;
    localparam int CW = 16;
    localparam logic [IW-1:0] NOPW = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] run_limit = '0;
    logic          core_rst_n;
    logic [AW-1:0] i_mem_addr;
    logic [IW-1:0] i_mem_data;
    logic          d_mem_we = 1'b0;
    logic          busy;
    logic          done;
    logic          halted;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] store_count;

    logic          model_on = 1'b0;
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] man_addr = '0;
    int            vecs = 0;
    int            errs = 0;
    int            n;

    polirv_stim_driver #(
        .I_ADDR_BITS(AW),
        .DEPTH(32),
        .INSTRUCTION_SIZE(IW),
        .RESET_CYCLES(2),
        .CNT_BITS(CW),
        .HALT_REPEAT(4),
        .NOP(NOPW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .start(start),
        .abort(abort),
        .run_limit(run_limit),
        .core_rst_n(core_rst_n),
        .i_mem_addr(i_mem_addr),
        .i_mem_data(i_mem_data),
        .d_mem_we(d_mem_we),
        .busy(busy),
        .done(done),
        .halted(halted),
        .timeout(timeout),
        .cycle_count(cycle_count),
        .store_count(store_count)
    );

    always #5 clk = ~clk;

    assign i_mem_addr = model_on ? pc : man_addr;

    // Core model: jal x0,0 (0x6F) spins in place, anything else steps the PC.
    always @(posedge clk) begin
        if (!core_rst_n) pc <= '0;
        else if (i_mem_data == 32'h0000006F) pc <= pc;
        else pc <= pc + 6'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
        load_we = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vecs++;
        if ({core_rst_n, busy, done, halted, timeout} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags got %b want 00000",
                     {core_rst_n, busy, done, halted, timeout});
        end
        vecs++;
        if (cycle_count !== 16'd0 || store_count !== 16'd0) begin
            errs++;
            $display("FAIL reset_counts got %0d/%0d want 0/0",
                     cycle_count, store_count);
        end
        vecs++;
        if (i_mem_data !== NOPW) begin
            errs++;
            $display("FAIL reset_data got %h want %h", i_mem_data, NOPW);
        end
    endtask

    task automatic test_halt();
        model_on = 1'b1;
        load(6'd0, 32'h00500093);
        load(6'd1, 32'h0000006F);
        run_limit = 16'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1 || core_rst_n !== 1'b0) begin
            errs++;
            $display("FAIL halt_t1 got busy=%b rst_n=%b want 1/0",
                     busy, core_rst_n);
        end
        tick();
        vecs++;
        if (core_rst_n !== 1'b0) begin
            errs++;
            $display("FAIL halt_t2 got rst_n=%b want 0", core_rst_n);
        end
        tick();
        vecs++;
        if (core_rst_n !== 1'b1 || i_mem_data !== 32'h00500093) begin
            errs++;
            $display("FAIL halt_run0 got rst_n=%b data=%h want 1/00500093",
                     core_rst_n, i_mem_data);
        end
        tick();
        vecs++;
        if (i_mem_data !== 32'h0000006F) begin
            errs++;
            $display("FAIL halt_run1 got data=%h want 0000006f", i_mem_data);
        end
        n = 1;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        vecs++;
        if (n !== 5) begin
            errs++;
            $display("FAIL halt_latency got %0d want 5", n);
        end
        vecs++;
        if ({halted, timeout, core_rst_n, busy} !== 4'b1000
            || cycle_count !== 16'd5) begin
            errs++;
            $display("FAIL halt_end got h/t/rn/b=%b cc=%0d want 1000 cc=5",
                     {halted, timeout, core_rst_n, busy}, cycle_count);
        end
    endtask

    task automatic test_limit();
        for (int i = 0; i < 32; i++) load(AW'(i), NOPW);
        model_on = 1'b1;
        run_limit = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vecs++;
        if (core_rst_n !== 1'b1) begin
            errs++;
            $display("FAIL limit_run0 got rst_n=%b want 1", core_rst_n);
        end
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        vecs++;
        if (n !== 10) begin
            errs++;
            $display("FAIL limit_latency got %0d want 10", n);
        end
        vecs++;
        if ({timeout, halted} !== 2'b10 || cycle_count !== 16'd10
            || store_count !== 16'd0) begin
            errs++;
            $display("FAIL limit_end got t/h=%b cc=%0d sc=%0d want 10 10 0",
                     {timeout, halted}, cycle_count, store_count);
        end
    endtask

    task automatic test_limit0();
        run_limit = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1 || core_rst_n !== 1'b0) begin
            errs++;
            $display("FAIL lim0_t1 got busy=%b rst_n=%b want 1/0",
                     busy, core_rst_n);
        end
        tick();
        vecs++;
        if (busy !== 1'b1 || core_rst_n !== 1'b0) begin
            errs++;
            $display("FAIL lim0_t2 got busy=%b rst_n=%b want 1/0",
                     busy, core_rst_n);
        end
        tick();
        vecs++;
        if ({done, timeout, halted, core_rst_n} !== 4'b1100
            || cycle_count !== 16'd0) begin
            errs++;
            $display("FAIL lim0_end got d/t/h/rn=%b cc=%0d want 1100 cc=0",
                     {done, timeout, halted, core_rst_n}, cycle_count);
        end
    endtask

    task automatic test_oob();
        model_on = 1'b0;
        load(6'd3, 32'h11111111);
        load(6'd40, 32'hBADBAD00);
        run_limit = 16'd20;
        man_addr = 6'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vecs++;
        if (i_mem_data !== NOPW || core_rst_n !== 1'b1) begin
            errs++;
            $display("FAIL oob_read got %h rst_n=%b want %h/1",
                     i_mem_data, core_rst_n, NOPW);
        end
        load_we = 1'b1;
        load_addr = 6'd3;
        load_data = 32'h22222222;
        tick();
        load_we = 1'b0;
        man_addr = 6'd8;
        #1;
        vecs++;
        if (i_mem_data !== NOPW) begin
            errs++;
            $display("FAIL oob_alias got %h want %h", i_mem_data, NOPW);
        end
        tick();
        man_addr = 6'd3;
        #1;
        vecs++;
        if (i_mem_data !== 32'h11111111) begin
            errs++;
            $display("FAIL run_write got %h want 11111111", i_mem_data);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        model_on = 1'b1;
        run_limit = 16'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        d_mem_we = 1'b1;
        tick();
        tick();
        d_mem_we = 1'b0;
        tick();
        d_mem_we = 1'b1;
        tick();
        d_mem_we = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vecs++;
        if ({busy, done, core_rst_n, halted, timeout} !== 5'b0) begin
            errs++;
            $display("FAIL abort_flags got %b want 00000",
                     {busy, done, core_rst_n, halted, timeout});
        end
        vecs++;
        if (store_count !== 16'd3) begin
            errs++;
            $display("FAIL abort_stores got %0d want 3", store_count);
        end
        tick();
        vecs++;
        if (store_count !== 16'd3 || busy !== 1'b0) begin
            errs++;
            $display("FAIL abort_hold got sc=%0d busy=%b want 3/0",
                     store_count, busy);
        end
    endtask

    task automatic test_rst_run();
        model_on = 1'b0;
        run_limit = 16'd30;
        man_addr = 6'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        man_addr = 6'd6;
        d_mem_we = 1'b1;
        tick();
        d_mem_we = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        load_we = 1'b1;
        load_addr = 6'd3;
        load_data = 32'h33333333;
        tick();
        vecs++;
        if ({core_rst_n, busy, done, halted, timeout} !== 5'b0
            || cycle_count !== 16'd0 || store_count !== 16'd0
            || i_mem_data !== NOPW) begin
            errs++;
            $display("FAIL rst_run got f=%b cc=%0d sc=%0d d=%h want 0 0 0 %h",
                     {core_rst_n, busy, done, halted, timeout},
                     cycle_count, store_count, i_mem_data, NOPW);
        end
        rst = 1'b0;
        start = 1'b0;
        load_we = 1'b0;
        tick();
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_start got busy=%b want 0", busy);
        end
        man_addr = 6'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vecs++;
        if (i_mem_data !== 32'h11111111 || core_rst_n !== 1'b1) begin
            errs++;
            $display("FAIL rst_table got %h rst_n=%b want 11111111/1",
                     i_mem_data, core_rst_n);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_halt();
        test_limit();
        test_limit0();
        test_oob();
        test_abort();
        test_rst_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
